// File: rtl/isqrt_share_arbiter.sv
// isqrt_share_arbiter: shares one fixed-latency isqrt among N_REQ requesters (round-robin; fixed priority with ISQRT_SHARE_ARBITER_FIXED_PRIO_EN).
// Latency: issue is combinational; res_vld/res_y follow isqrt_y_vld by exactly 1 cycle.
// Backpressure: req_rdy is held low while MAX_OUT results are in flight; the result side cannot stall.
module isqrt_share_arbiter #(
  parameter int N_REQ   = 3,
  parameter int W       = 32,
  parameter int MAX_OUT = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_vld,
  input  logic [N_REQ*W-1:0]           req_x,
  output logic [N_REQ-1:0]             req_rdy,
  output logic                         isqrt_x_vld,
  output logic [W-1:0]                 isqrt_x,
  input  logic                         isqrt_y_vld,
  input  logic [W-1:0]                 isqrt_y,
  output logic [N_REQ-1:0]             res_vld,
  output logic [W-1:0]                 res_y,
  output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
  output logic                         err
);
  localparam int TAG_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam int AW    = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  logic [TAG_W-1:0] start_idx;
  logic [TAG_W-1:0] gnt_idx;
  logic [TAG_W-1:0] cand;
  logic             gnt_vld;
  logic [TAG_W-1:0] tag_mem [MAX_OUT];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [TAG_W-1:0] pop_tag;
  logic             fifo_empty;
  logic             pop;

`ifdef ISQRT_SHARE_ARBITER_FIXED_PRIO_EN
  assign start_idx = '0;
`else
  logic [TAG_W-1:0] ptr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr <= '0;
    end else if (gnt_vld) begin
      ptr <= (gnt_idx == TAG_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  assign start_idx = ptr;
`endif

  // Full is judged on the registered count, so a same-cycle pop never frees a slot.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    req_rdy = '0;
    if (rst && (int'(outstanding) < MAX_OUT)) begin
      for (int k = 0; k < N_REQ; k++) begin
        cand = ((int'(start_idx) + k) >= N_REQ) ? TAG_W'(int'(start_idx) + k - N_REQ)
                                                : TAG_W'(int'(start_idx) + k);
        if (!gnt_vld && req_vld[cand]) begin
          gnt_vld = 1'b1;
          gnt_idx = cand;
        end
      end
      req_rdy[gnt_idx] = gnt_vld;
    end
  end

  always_comb begin
    isqrt_x = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_rdy[i]) isqrt_x = req_x[i*W +: W];
    end
  end

  assign isqrt_x_vld = gnt_vld;

  // Tag FIFO: one requester index per result in flight, popped in issue order.
  assign fifo_empty = (outstanding == '0);
  assign pop        = isqrt_y_vld && !fifo_empty;
  assign pop_tag    = tag_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
    end else begin
      if (gnt_vld) wr_ptr <= (wr_ptr == AW'(MAX_OUT - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)     rd_ptr <= (rd_ptr == AW'(MAX_OUT - 1)) ? '0 : rd_ptr + 1'b1;
      outstanding <= outstanding + CNT_W'(gnt_vld) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (gnt_vld) tag_mem[wr_ptr] <= gnt_idx;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      res_vld <= '0;
      res_y   <= '0;
      err     <= 1'b0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        res_vld[i] <= pop && (int'(pop_tag) == i);
      end
      if (pop) res_y <= isqrt_y;
      if (isqrt_y_vld && fifo_empty) err <= 1'b1;
    end
  end
endmodule
